ahb3_sram_slave: RTL and testbench
==================================

Name: ahb3_sram_slave

Overview:
- AHB-lite slave (responder) with an internal word-organised SRAM; it is the opposite end of the master-side transfers the verification environment drives.
- Decodes address-phase controls, inserts programmable wait states, performs byte/halfword/word reads and writes, and returns a two-cycle ERROR response for illegal transfers.
- Sits behind the system decoder as the DUT-side memory target for directed and random AHB-lite traffic.

Parameters:
MEM_DEPTH, 256, number of 32-bit words; byte address range 0 to 4*MEM_DEPTH-1
WAIT_STATES, 0, HREADYOUT-low cycles inserted in every accepted non-error transfer (0..15)

Ports:
HCLK  input  1  system clock, all state on rising edge
HRESETn  input  1  asynchronous active-low reset
i_HSEL  input  1  slave select from decoder
i_HADDR  input  32  byte address, address phase
i_HWRITE  input  1  1=write, 0=read, address phase
i_HTRANS  input  2  0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ
i_HSIZE  input  3  0 byte, 1 halfword, 2 word; others illegal
i_HBURST  input  3  burst type; captured, no effect on addressing
i_HWDATA  input  32  write data, data phase
i_HREADY  input  1  bus-level ready (previous transfer complete)
o_HRDATA  output  32  read data
o_HREADYOUT  output  1  slave ready
o_HRESP  output  1  0 OKAY, 1 ERROR

Behaviour:
- Reset (HRESETn low, asynchronous): state IDLE, o_HREADYOUT=1, o_HRESP=0, o_HRDATA=0, captured controls cleared, wait counter 0. Memory contents are not reset. A transfer in flight when reset asserts is abandoned; a pending write is not committed.
- Accept: the address phase is sampled on a rising edge when i_HSEL & i_HREADY & i_HTRANS[1]. The slave captures HADDR, HWRITE, HSIZE and HBURST.
- IDLE/BUSY, or HSEL low: not accepted. The next cycle returns OKAY with zero wait states and no memory access.
- Illegal transfer conditions:
  - HADDR[31:2] >= MEM_DEPTH;
  - HSIZE > 2;
  - HSIZE=1 with HADDR[0]=1;
  - HSIZE=2 with HADDR[1:0]!=0.
- FSM states:
  - IDLE: HREADYOUT=1, HRESP=0. Legal accept goes to WAIT if WAIT_STATES>0, else DATA. Illegal accept goes to ERR1.
  - WAIT: HREADYOUT=0, HRESP=0. The counter loads WAIT_STATES-1 on entry and decrements each cycle. At 0 the FSM goes to DATA.
  - DATA: HREADYOUT=1, HRESP=0. This is the completing cycle. A new accept in this cycle follows the same rules as IDLE; with no accept, the FSM returns to IDLE.
  - ERR1: HREADYOUT=0, HRESP=1. Always goes to ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. Accepts a new address phase like IDLE, so back-to-back transfers are allowed after an error.
- With WAIT_STATES=0, DATA coincides with the cycle after accept. Pipelined NONSEQ/SEQ streams then complete one per cycle.
- Write commit: occurs on the rising edge ending DATA.
  - Only lanes selected by size/address are updated, little-endian.
  - Byte: lane HADDR[1:0].
  - Halfword: lanes {HADDR[1],0}+1..0.
  - Word: all four lanes.
  - HWDATA is sampled on that edge only.
  - Errored writes never modify memory.
- Read data:
  - During DATA of a read, o_HRDATA = full 32-bit word mem[addr[31:2]] with all lanes driven. The master selects the lanes.
  - In all other cycles o_HRDATA=0, including WAIT, ERR1/ERR2 and write data phases.
  - Read-after-write to the same address back-to-back returns the new data. The write commits before the read's DATA cycle, so no bypass is needed.
- Inputs are not sampled while o_HREADYOUT=0. Changes to HADDR/HTRANS during WAIT or ERR1 are ignored.
- No address wrap: addresses at or beyond 4*MEM_DEPTH error rather than alias.

Test Plan:
- Reset then word write 0x0000_0010 data 0xDEAD_BEEF, read 0x10 (WAIT_STATES=0) -> OKAY, HREADYOUT never low, HRDATA=0xDEADBEEF in read data cycle.
- Byte write 0xAA to 0x13 over word 0x11223344 at 0x10, then read 0x10 -> HRDATA=0xAA223344; halfword write 0x5566 to 0x10 -> subsequent read 0xAA225566.
- WAIT_STATES=3, NONSEQ read then SEQ read -> each transfer shows exactly 3 cycles HREADYOUT=0 then 1 cycle HREADYOUT=1; address changes during waits ignored.
- Word read at 0x0000_0402 (misaligned) and word write at 0x0000_0400 (out of range with MEM_DEPTH=256) -> ERR1 (HREADYOUT=0,HRESP=1), ERR2 (1,1); memory unchanged; an immediately following legal NONSEQ in ERR2 completes OKAY.
- IDLE and BUSY with HSEL=1, and NONSEQ with HSEL=0 -> HREADYOUT=1, HRESP=0, HRDATA=0, no memory change.
- Assert HRESETn low during WAIT of a write to 0x20 (previous content 0x0) -> outputs immediately HREADYOUT=1, HRESP=0, HRDATA=0; read of 0x20 after release returns 0x00000000.

Source files
------------

// File: rtl/ahb3_sram_slave.sv
// AHB-lite SRAM responder: word-organised memory, programmable wait states,
// byte/halfword/word lanes and a two-cycle ERROR response for illegal transfers.
module ahb3_sram_slave #(
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        i_HSEL,
  input  logic [31:0] i_HADDR,
  input  logic        i_HWRITE,
  input  logic [1:0]  i_HTRANS,
  input  logic [2:0]  i_HSIZE,
  input  logic [2:0]  i_HBURST,
  input  logic [31:0] i_HWDATA,
  input  logic        i_HREADY,
  output logic [31:0] o_HRDATA,
  output logic        o_HREADYOUT,
  output logic        o_HRESP
);

  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  state_t          state;
  logic [AW+1:0]   addr_q;
  logic            write_q;
  logic [1:0]      size_q;
  logic [2:0]      burst_q;
  logic [3:0]      wait_cnt;
  logic            hreadyout_q;
  logic            hresp_q;
  logic [3:0]      lane;
  logic [AW-1:0]   word_idx;
  logic            accept;
  logic            illegal;
  logic [31:0]     mem [MEM_DEPTH];

  // Burst type and HTRANS[0] are captured/observed but never steer addressing.
  logic unused_inputs;
  assign unused_inputs = ^{i_HTRANS[0], burst_q};

  // HREADYOUT is high exactly in the states that may take a new address phase.
  assign accept  = i_HSEL & i_HREADY & i_HTRANS[1] & hreadyout_q;
  assign illegal = ({2'b00, i_HADDR[31:2]} >= 32'(MEM_DEPTH))
                 | (i_HSIZE > 3'd2)
                 | ((i_HSIZE == 3'd1) & i_HADDR[0])
                 | ((i_HSIZE == 3'd2) & (|i_HADDR[1:0]));

  assign word_idx = addr_q[AW+1:2];

  always_comb begin
    lane = 4'b1111;
    case (size_q)
      2'd0:    lane = 4'b0001 << addr_q[1:0];
      2'd1:    lane = addr_q[1] ? 4'b1100 : 4'b0011;
      default: lane = 4'b1111;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state       <= S_IDLE;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      addr_q      <= '0;
      write_q     <= 1'b0;
      size_q      <= 2'd0;
      burst_q     <= 3'd0;
      wait_cnt    <= 4'd0;
    end else begin
      case (state)
        S_WAIT: begin
          if (wait_cnt == 4'd0) begin
            state       <= S_DATA;
            hreadyout_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        S_ERR1: begin
          state       <= S_ERR2;
          hreadyout_q <= 1'b1;
          hresp_q     <= 1'b1;
        end
        default: begin
          if (accept) begin
            addr_q  <= i_HADDR[AW+1:0];
            write_q <= i_HWRITE;
            size_q  <= i_HSIZE[1:0];
            burst_q <= i_HBURST;
            if (illegal) begin
              state       <= S_ERR1;
              hreadyout_q <= 1'b0;
              hresp_q     <= 1'b1;
            end else if (WAIT_STATES > 0) begin
              state       <= S_WAIT;
              hreadyout_q <= 1'b0;
              hresp_q     <= 1'b0;
              wait_cnt    <= 4'(WAIT_STATES - 1);
            end else begin
              state       <= S_DATA;
              hreadyout_q <= 1'b1;
              hresp_q     <= 1'b0;
            end
          end else begin
            state       <= S_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
          end
        end
      endcase
    end
  end

  // Commit on the edge that ends DATA, so a back-to-back read sees the new word.
  always_ff @(posedge HCLK) begin
    if (state == S_DATA && write_q) begin
      for (int i = 0; i < 4; i++) begin
        if (lane[i]) mem[word_idx][8*i +: 8] <= i_HWDATA[8*i +: 8];
      end
    end
  end

  assign o_HRDATA    = (state == S_DATA && !write_q) ? mem[word_idx] : 32'd0;
  assign o_HREADYOUT = hreadyout_q;
  assign o_HRESP     = hresp_q;

endmodule

// File: tb/tb_ahb3_sram_slave.sv
// Bench for ahb3_sram_slave: two instances (0 and 3 wait states) driven from one
// bus, checked cycle by cycle against a byte-level memory model.
module tb_ahb3_sram_slave;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        hsel;
  logic [31:0] haddr;
  logic        hwrite;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  bit          tgt;
  logic [31:0] rd0, rd3;
  logic        ro0, ro3, rs0, rs3;
  logic        bus_ready;

  always #5 HCLK = ~HCLK;

  assign bus_ready = tgt ? ro3 : ro0;

  ahb3_sram_slave #(.MEM_DEPTH(256), .WAIT_STATES(0)) dut0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .i_HSEL(hsel & !tgt), .i_HADDR(haddr),
    .i_HWRITE(hwrite), .i_HTRANS(htrans), .i_HSIZE(hsize), .i_HBURST(hburst),
    .i_HWDATA(hwdata), .i_HREADY(bus_ready), .o_HRDATA(rd0),
    .o_HREADYOUT(ro0), .o_HRESP(rs0));

  ahb3_sram_slave #(.MEM_DEPTH(256), .WAIT_STATES(3)) dut3 (
    .HCLK(HCLK), .HRESETn(HRESETn), .i_HSEL(hsel & tgt), .i_HADDR(haddr),
    .i_HWRITE(hwrite), .i_HTRANS(htrans), .i_HSIZE(hsize), .i_HBURST(hburst),
    .i_HWDATA(hwdata), .i_HREADY(bus_ready), .o_HRDATA(rd3),
    .o_HREADYOUT(ro3), .o_HRESP(rs3));

  logic [31:0] mdl [2][256];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] obs_rd;

  // next address phase, driven during the completing cycle of a chained transfer
  logic        nx_sel;
  logic [31:0] nx_a;
  logic        nx_w;
  logic [2:0]  nx_sz;
  logic [1:0]  nx_tr;

  function automatic bit legal(input logic [31:0] a, input logic [2:0] sz);
    if ((a >> 2) >= 32'd256) return 1'b0;
    if (sz > 3'd2) return 1'b0;
    if ((a % (32'd1 << sz)) != 32'd0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_write(input int t, input logic [31:0] a, input logic [2:0] sz,
                             input logic [31:0] wd);
    for (int i = 0; i < (1 << sz); i++) begin
      int b;
      int wi;
      b  = int'((a + 32'(i)) % 32'd4);
      wi = int'((a + 32'(i)) / 32'd4);
      mdl[t][wi][8*b +: 8] = wd[8*b +: 8];
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_bus();
    hsel = 1'b0; haddr = 32'd0; hwrite = 1'b0; htrans = 2'd0; hsize = 3'd0; hburst = 3'd0;
  endtask

  task automatic drive_addr(input logic sel, input logic [31:0] a, input logic w,
                            input logic [2:0] sz, input logic [1:0] tr);
    hsel = sel; haddr = a; hwrite = w; hsize = sz; htrans = tr;
    hburst = 3'($urandom_range(0, 7));
  endtask

  task automatic junk();
    hsel = 1'b1; haddr = $urandom; hwrite = 1'($urandom); htrans = 2'($urandom);
    hsize = 3'($urandom); hwdata = $urandom;
  endtask

  // One transfer from address phase to completion; every response cycle is checked.
  task automatic xfer(input string tag, input int t, input logic sel, input logic [31:0] a,
                      input logic w, input logic [2:0] sz, input logic [1:0] tr,
                      input logic [31:0] wd, input bit addr_done, input bit chain);
    bit acc, ok, last;
    int n, ws;
    logic        e_rdy, e_rsp, o_rdy, o_rsp;
    logic [31:0] e_dat, o_dat;
    tgt = (t != 0);
    if (!addr_done) begin
      drive_addr(sel, a, w, sz, tr);
      @(posedge HCLK); #1;
    end
    acc = sel && tr[1];
    ok  = legal(a, sz);
    ws  = (t != 0) ? 3 : 0;
    n   = !acc ? 1 : (!ok ? 2 : ws + 1);
    for (int c = 0; c < n; c++) begin
      last = (c == n - 1);
      if (last) begin
        if (chain) drive_addr(nx_sel, nx_a, nx_w, nx_sz, nx_tr);
        else idle_bus();
        hwdata = wd;
      end else begin
        junk();
      end
      @(negedge HCLK);
      if (!acc) begin
        e_rdy = 1'b1; e_rsp = 1'b0; e_dat = 32'd0;
      end else if (!ok) begin
        e_rdy = (c == 1); e_rsp = 1'b1; e_dat = 32'd0;
      end else begin
        e_rdy = last; e_rsp = 1'b0;
        e_dat = (last && !w) ? mdl[t][a[9:2]] : 32'd0;
      end
      o_rdy = (t != 0) ? ro3 : ro0;
      o_rsp = (t != 0) ? rs3 : rs0;
      o_dat = (t != 0) ? rd3 : rd0;
      chk($sformatf("%s.rdy%0d", tag, c), {31'd0, o_rdy}, {31'd0, e_rdy});
      chk($sformatf("%s.rsp%0d", tag, c), {31'd0, o_rsp}, {31'd0, e_rsp});
      chk($sformatf("%s.dat%0d", tag, c), o_dat, e_dat);
      if (last) obs_rd = o_dat;
      @(posedge HCLK);
      if (last && acc && ok && w) model_write(t, a, sz, wd);
      #1;
    end
  endtask

  task automatic rand_xfer(output logic sel, output logic [31:0] a, output logic w,
                           output logic [2:0] sz, output logic [1:0] tr, output logic [31:0] wd);
    sel = ($urandom_range(0, 9) != 0);
    tr  = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
    sz  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
    a   = ($urandom_range(0, 9) == 0) ? 32'h400 + $urandom_range(0, 15) : $urandom_range(0, 63);
    w   = 1'($urandom);
    wd  = $urandom;
  endtask

  initial begin
    logic        s;
    logic [31:0] a, d;
    logic        w;
    logic [2:0]  z;
    logic [1:0]  r;
    HRESETn = 1'b0;
    tgt = 1'b0;
    idle_bus();
    hwdata = 32'd0;
    obs_rd = 32'd0;
    #12;
    chk("rst.rdy0", {31'd0, ro0}, 32'd1);
    chk("rst.rsp0", {31'd0, rs0}, 32'd0);
    chk("rst.dat0", rd0, 32'd0);
    chk("rst.rdy3", {31'd0, ro3}, 32'd1);
    chk("rst.rsp3", {31'd0, rs3}, 32'd0);
    chk("rst.dat3", rd3, 32'd0);
    @(negedge HCLK); HRESETn = 1'b1;
    @(posedge HCLK); #1;

    // give the words the random traffic reads a defined starting value
    for (int t = 0; t < 2; t++)
      for (int i = 0; i < 16; i++)
        xfer("init", t, 1'b1, 32'(i * 4), 1'b1, 3'd2, 2'd2, $urandom, 1'b0, 1'b0);

    xfer("wr10", 0, 1'b1, 32'h10, 1'b1, 3'd2, 2'd2, 32'hDEADBEEF, 1'b0, 1'b0);
    xfer("rd10", 0, 1'b1, 32'h10, 1'b0, 3'd2, 2'd2, 32'd0, 1'b0, 1'b0);
    chk("rd10.const", obs_rd, 32'hDEADBEEF);

    xfer("wrw", 0, 1'b1, 32'h10, 1'b1, 3'd2, 2'd2, 32'h11223344, 1'b0, 1'b0);
    xfer("wrb", 0, 1'b1, 32'h13, 1'b1, 3'd0, 2'd2, 32'hAA000000, 1'b0, 1'b0);
    xfer("rdb", 0, 1'b1, 32'h10, 1'b0, 3'd2, 2'd2, 32'd0, 1'b0, 1'b0);
    chk("byte.const", obs_rd, 32'hAA223344);
    xfer("wrh", 0, 1'b1, 32'h10, 1'b1, 3'd1, 2'd2, 32'h00005566, 1'b0, 1'b0);
    xfer("rdh", 0, 1'b1, 32'h10, 1'b0, 3'd2, 2'd2, 32'd0, 1'b0, 1'b0);
    chk("half.const", obs_rd, 32'hAA225566);

    // three wait states, NONSEQ then SEQ chained; junk on the bus during the waits
    nx_sel = 1'b1; nx_a = 32'h14; nx_w = 1'b0; nx_sz = 3'd2; nx_tr = 2'd3;
    xfer("ws_ns", 1, 1'b1, 32'h10, 1'b0, 3'd2, 2'd2, 32'd0, 1'b0, 1'b1);
    xfer("ws_sq", 1, 1'b1, 32'h14, 1'b0, 3'd2, 2'd3, 32'd0, 1'b1, 1'b0);

    // errors, then a legal NONSEQ issued in ERR2
    xfer("mis", 0, 1'b1, 32'h402, 1'b0, 3'd2, 2'd2, 32'd0, 1'b0, 1'b0);
    xfer("mis2", 0, 1'b1, 32'h002, 1'b0, 3'd2, 2'd2, 32'd0, 1'b0, 1'b0);
    nx_sel = 1'b1; nx_a = 32'h10; nx_w = 1'b0; nx_sz = 3'd2; nx_tr = 2'd2;
    xfer("oor", 0, 1'b1, 32'h400, 1'b1, 3'd2, 2'd2, 32'h12345678, 1'b0, 1'b1);
    xfer("after_err", 0, 1'b1, 32'h10, 1'b0, 3'd2, 2'd2, 32'd0, 1'b1, 1'b0);
    chk("after_err.const", obs_rd, 32'hAA225566);
    xfer("err3", 1, 1'b1, 32'h001, 1'b1, 3'd1, 2'd2, 32'hFFFFFFFF, 1'b0, 1'b0);

    // not accepted: IDLE/BUSY selected, NONSEQ deselected
    xfer("idle", 0, 1'b1, 32'h10, 1'b1, 3'd2, 2'd0, 32'h0BADF00D, 1'b0, 1'b0);
    xfer("busy", 0, 1'b1, 32'h10, 1'b1, 3'd2, 2'd1, 32'h0BADF00D, 1'b0, 1'b0);
    xfer("nosel", 0, 1'b0, 32'h10, 1'b1, 3'd2, 2'd2, 32'h0BADF00D, 1'b0, 1'b0);
    xfer("rd_keep", 0, 1'b1, 32'h10, 1'b0, 3'd2, 2'd2, 32'd0, 1'b0, 1'b0);
    chk("keep.const", obs_rd, 32'hAA225566);

    // random pipelined streams on both instances
    for (int t = 0; t < 2; t++) begin
      rand_xfer(s, a, w, z, r, d);
      for (int i = 0; i < 60; i++) begin
        logic        cs, cw;
        logic [31:0] ca, cd;
        logic [2:0]  cz;
        logic [1:0]  cr;
        cs = s; ca = a; cw = w; cz = z; cr = r; cd = d;
        rand_xfer(s, a, w, z, r, d);
        nx_sel = s; nx_a = a; nx_w = w; nx_sz = z; nx_tr = r;
        xfer($sformatf("rnd%0d_%0d", t, i), t, cs, ca, cw, cz, cr, cd, i > 0, i < 59);
      end
    end

    // reset during the wait states of a write abandons it
    xfer("clr20", 1, 1'b1, 32'h20, 1'b1, 3'd2, 2'd2, 32'd0, 1'b0, 1'b0);
    tgt = 1'b1;
    drive_addr(1'b1, 32'h20, 1'b1, 3'd2, 2'd2);
    @(posedge HCLK); #1;
    idle_bus();
    hwdata = 32'hFFFFFFFF;
    @(negedge HCLK);
    chk("rwait.rdy", {31'd0, ro3}, 32'd0);
    #2 HRESETn = 1'b0;
    #1;
    chk("rasync.rdy", {31'd0, ro3}, 32'd1);
    chk("rasync.rsp", {31'd0, rs3}, 32'd0);
    chk("rasync.dat", rd3, 32'd0);
    @(posedge HCLK);
    @(negedge HCLK); HRESETn = 1'b1;
    @(posedge HCLK); #1;
    xfer("rd20", 1, 1'b1, 32'h20, 1'b0, 3'd2, 2'd2, 32'd0, 1'b0, 1'b0);
    chk("rd20.const", obs_rd, 32'h00000000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
